line_sensor_reader: RTL and testbench

- Upstream feeder for the max_finder peak-search stage.
- Generates the line-CCD timing (shift/SH pulse and pixel clock) and captures the 8-bit ADC sample once per pixel.
- Emits the frame start pulse plus a data_valid/data_in/data_pos stream that drives max_finder's start, data_valid, data_in and data_pos inputs directly.
- Supports single-shot or continuous frame acquisition.

---
 rtl/line_sensor_reader.sv | 149 ++++++++++++++
 tb/tb_line_sensor_reader.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/line_sensor_reader.sv
// Line-CCD timing generator and ADC capture feeding the max_finder peak search.
// Optional BLACK_LEVEL_SUB_EN subtracts the last dummy-pixel sample from each active pixel.
module line_sensor_reader #(
    parameter int PIXEL_COUNT  = 512,
    parameter int DUMMY_PIXELS = 16,
    parameter int PIX_DIV      = 8,
    parameter int SH_WIDTH     = 8,
    parameter int SAMPLE_PHASE = 5
) (
    input  logic       clk_in,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] adc_data,
    output logic       sensor_sh,
    output logic       sensor_clk,
    output logic       start,
    output logic       data_valid,
    output logic [7:0] data_in,
    output logic [8:0] data_pos,
    output logic       busy,
    output logic       frame_done
);

    localparam int PH_W = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam logic [PH_W-1:0] PH_LAST   = PH_W'(PIX_DIV - 1);
    localparam logic [PH_W-1:0] PH_SAMPLE = PH_W'(SAMPLE_PHASE);
    localparam logic [PH_W-1:0] PH_HALF   = PH_W'(PIX_DIV / 2);
    localparam logic [15:0] SH_LAST     = 16'(SH_WIDTH - 1);
    localparam logic [15:0] DUMMY_LAST  = 16'(DUMMY_PIXELS - 1);
    localparam logic [15:0] ACTIVE_LAST = 16'(PIXEL_COUNT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SH,
        S_DUMMY,
        S_ACTIVE,
        S_DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [15:0]       sh_cnt;
    logic [PH_W-1:0]   ph;
    logic [15:0]       pix;
    logic              ph_last;
    logic              sample;
    logic [7:0]        sample_val;

    assign ph_last = (ph == PH_LAST);
    assign sample  = (state_q == S_ACTIVE) && (ph == PH_SAMPLE);

    always_ff @(posedge clk_in) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        sensor_sh  = 1'b0;
        sensor_clk = 1'b0;
        start      = 1'b0;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) state_d = S_SH;
            end
            S_SH: begin
                sensor_sh = 1'b1;
                busy      = 1'b1;
                start     = (sh_cnt == 16'd0);
                if (sh_cnt == SH_LAST) state_d = (DUMMY_PIXELS == 0) ? S_ACTIVE : S_DUMMY;
            end
            S_DUMMY: begin
                busy       = 1'b1;
                sensor_clk = (ph < PH_HALF);
                if (ph_last && pix == DUMMY_LAST) state_d = S_ACTIVE;
            end
            S_ACTIVE: begin
                busy       = 1'b1;
                sensor_clk = (ph < PH_HALF);
                if (ph_last && pix == ACTIVE_LAST) state_d = S_DONE;
            end
            S_DONE: begin
                frame_done = 1'b1;
                state_d    = enable ? S_SH : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Every state change restarts the timing counters from zero.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            sh_cnt <= '0;
            ph     <= '0;
            pix    <= '0;
        end else if (state_d != state_q) begin
            sh_cnt <= '0;
            ph     <= '0;
            pix    <= '0;
        end else if (state_q == S_SH) begin
            sh_cnt <= sh_cnt + 16'd1;
        end else if (state_q == S_DUMMY || state_q == S_ACTIVE) begin
            ph <= ph_last ? '0 : ph + 1'b1;
            if (ph_last) pix <= pix + 16'd1;
        end
    end

`ifdef BLACK_LEVEL_SUB_EN
    logic [7:0] black_lvl;

    function automatic logic [7:0] sub_sat(input logic [7:0] a, input logic [7:0] b);
        return (a > b) ? (a - b) : 8'd0;
    endfunction

    always_ff @(posedge clk_in) begin
        if (rst) begin
            black_lvl <= '0;
        end else if (state_q == S_DUMMY && ph == PH_SAMPLE && pix == DUMMY_LAST) begin
            black_lvl <= adc_data;
        end
    end

    assign sample_val = sub_sat(adc_data, black_lvl);
`else
    assign sample_val = adc_data;
`endif

    // Output register stage: one cycle from the sampled adc_data to data_valid.
    always_ff @(posedge clk_in) begin
        if (rst) begin
            data_valid <= 1'b0;
            data_in    <= '0;
            data_pos   <= '0;
        end else begin
            data_valid <= sample;
            if (start) data_pos <= '0;
            if (sample) begin
                data_in  <= sample_val;
                data_pos <= pix[8:0];
            end
        end
    end

endmodule

// File: tb/tb_line_sensor_reader.sv
// Directed bench for line_sensor_reader with a frame-offset reference model and literal spot checks.
module tb_line_sensor_reader;

    localparam int PC   = 8;
    localparam int DUM  = 2;
    localparam int DIV  = 4;
    localparam int SHW  = 3;
    localparam int SP   = 2;
    localparam int ACT0 = SHW + DUM * DIV;
    localparam int FLEN = ACT0 + PC * DIV + 1;
    localparam int BL_T = SHW + (DUM - 1) * DIV + SP;

    logic       clk;
    logic       rst;
    logic       enable;
    logic [7:0] adc;
    logic       sensor_sh, sensor_clk, start, data_valid, busy, frame_done;
    logic [7:0] data_in;
    logic [8:0] data_pos;

    int checks   = 0;
    int failures = 0;

    line_sensor_reader #(
        .PIXEL_COUNT(PC), .DUMMY_PIXELS(DUM), .PIX_DIV(DIV),
        .SH_WIDTH(SHW), .SAMPLE_PHASE(SP)
    ) dut (
        .clk_in(clk), .rst(rst), .enable(enable), .adc_data(adc),
        .sensor_sh(sensor_sh), .sensor_clk(sensor_clk), .start(start),
        .data_valid(data_valid), .data_in(data_in), .data_pos(data_pos),
        .busy(busy), .frame_done(frame_done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: frame described by its offset t from the first SH cycle.
    bit   armed    = 1'b0;
    bit   in_frame = 1'b0;
    int   t        = 0;
    bit   e_dv     = 1'b0;
    int   e_din    = 0;
    int   e_pos    = 0;
    int   bl       = 0;

    always @(negedge clk) begin
        int rel;
        if (armed) begin
            chk("sensor_sh", int'(sensor_sh), int'(in_frame && t < SHW));
            chk("start", int'(start), int'(in_frame && t == 0));
            chk("busy", int'(busy), int'(in_frame && t < FLEN - 1));
            chk("frame_done", int'(frame_done), int'(in_frame && t == FLEN - 1));
            chk("sensor_clk", int'(sensor_clk),
                int'(in_frame && t >= SHW && t < FLEN - 1 && ((t - SHW) % DIV) < DIV / 2));
            chk("data_valid", int'(data_valid), int'(e_dv));
            chk("data_in", int'(data_in), e_din);
            chk("data_pos", int'(data_pos), e_pos);
        end
        if (rst) begin
            in_frame = 1'b0;
            e_dv     = 1'b0;
            e_din    = 0;
            e_pos    = 0;
            bl       = 0;
            armed    = 1'b1;
        end else begin
            rel  = t - ACT0;
            e_dv = in_frame && t >= ACT0 && t < FLEN - 1 && (rel % DIV) == SP;
            if (in_frame && t == 0) e_pos = 0;
            if (e_dv) begin
                e_pos = rel / DIV;
`ifdef BLACK_LEVEL_SUB_EN
                e_din = (int'(adc) > bl) ? int'(adc) - bl : 0;
`else
                e_din = int'(adc);
`endif
            end
            if (in_frame && t == BL_T) bl = int'(adc);
            if (in_frame) begin
                if (t == FLEN - 1) begin
                    if (enable) t = 0;
                    else in_frame = 1'b0;
                end else begin
                    t++;
                end
            end else if (enable) begin
                in_frame = 1'b1;
                t        = 0;
            end
        end
    end

    int cap_dv[FLEN], cap_din[FLEN], cap_pos[FLEN];
    int cap_start[FLEN], cap_sh[FLEN], cap_busy[FLEN], cap_fd[FLEN];

    function automatic logic [7:0] adc_for(input int mode, input int ft);
        int p;
        p = (ft >= ACT0) ? (ft - ACT0) / DIV : 0;
        if (mode == 0) return (ft >= ACT0 && ft < FLEN - 1) ? 8'(10 * p + 5) : 8'd0;
        if (ft >= SHW && ft < ACT0) return 8'd30;
        if (ft >= ACT0 && ft < FLEN - 1) begin
            case (p)
                0: return 8'd100;
                1: return 8'd20;
                2: return 8'd30;
                default: return 8'd50;
            endcase
        end
        return 8'd0;
    endfunction

    task automatic run_frame(input bit pre, input int en_until, input int rst_at,
                             input int mode, output int ndv);
        ndv = 0;
        if (pre) begin
            rst = 1'b0; enable = 1'b1; adc = 8'd0;
            @(posedge clk); #1;
        end
        for (int ft = 0; ft < FLEN; ft++) begin
            rst    = (ft == rst_at);
            enable = (ft < en_until);
            adc    = adc_for(mode, ft);
            @(negedge clk);
            cap_dv[ft]    = int'(data_valid);
            cap_din[ft]   = int'(data_in);
            cap_pos[ft]   = int'(data_pos);
            cap_start[ft] = int'(start);
            cap_sh[ft]    = int'(sensor_sh);
            cap_busy[ft]  = int'(busy);
            cap_fd[ft]    = int'(frame_done);
            ndv += int'(data_valid);
            @(posedge clk); #1;
        end
    endtask

    task automatic idle(input int n, output int nact);
        nact = 0;
        for (int i = 0; i < n; i++) begin
            rst = 1'b0; enable = 1'b0; adc = 8'(i * 7);
            @(negedge clk);
            nact += int'(data_valid) + int'(start) + int'(busy);
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int ndv, nact;
        rst = 1'b1; enable = 1'b0; adc = 8'd0;
        repeat (2) begin @(posedge clk); #1; end
        rst = 1'b0;
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_valid", int'(data_valid), 0);
        chk("reset_pos", int'(data_pos), 0);
        @(posedge clk); #1;
        idle(3, nact);

        // Scenario 1: single frame, enable pulsed for one cycle
        run_frame(1'b1, 0, -1, 0, ndv);
        chk("s1_start0", cap_start[0], 1);
        chk("s1_start1", cap_start[1], 0);
        chk("s1_sh2", cap_sh[2], 1);
        chk("s1_sh3", cap_sh[3], 0);
        chk("s1_dv14", cap_dv[14], 1);
        chk("s1_din14", cap_din[14], 5);
        chk("s1_pos14", cap_pos[14], 0);
        chk("s1_din18", cap_din[18], 15);
        chk("s1_din42", cap_din[42], 75);
        chk("s1_pos42", cap_pos[42], 7);
        chk("s1_fd43", cap_fd[43], 1);
        chk("s1_busy43", cap_busy[43], 0);
        chk("s1_ndv", ndv, 8);
        idle(4, nact);
        chk("s1_idle_after", nact, 0);

        // Scenario 2: enable held, back-to-back frames
        run_frame(1'b1, FLEN, -1, 0, ndv);
        chk("s2_ndv_a", ndv, 8);
        run_frame(1'b0, FLEN - 1, -1, 0, ndv);
        chk("s2_start_b", cap_start[0], 1);
        chk("s2_sh_b", cap_sh[0], 1);
        chk("s2_pos_b0", cap_pos[0], 7);
        chk("s2_pos_b1", cap_pos[1], 0);
        chk("s2_ndv_b", ndv, 8);
        chk("s2_fd_b", cap_fd[43], 1);
        idle(4, nact);
        chk("s2_idle_after", nact, 0);

        // Scenario 3: reset in the middle of ACTIVE
        run_frame(1'b1, 0, 20, 0, ndv);
        chk("s3_pos20", cap_pos[20], 1);
        chk("s3_din20", cap_din[20], 15);
        chk("s3_busy21", cap_busy[21], 0);
        chk("s3_pos21", cap_pos[21], 0);
        chk("s3_din21", cap_din[21], 0);
        chk("s3_ndv", ndv, 2);
        idle(20, nact);
        chk("s3_idle_after", nact, 0);

        // Scenario 4: enable dropped at cycle 5
        run_frame(1'b1, 5, -1, 0, ndv);
        chk("s4_ndv", ndv, 8);
        chk("s4_fd43", cap_fd[43], 1);
        idle(6, nact);
        chk("s4_idle_after", nact, 0);

        // Scenarios 5/6: black level from the last dummy sample
        run_frame(1'b1, 0, -1, 1, ndv);
`ifdef BLACK_LEVEL_SUB_EN
        chk("s5_din14", cap_din[14], 70);
        chk("s5_din18", cap_din[18], 0);
        chk("s5_din22", cap_din[22], 0);
`else
        chk("s6_din14", cap_din[14], 100);
        chk("s6_din18", cap_din[18], 20);
        chk("s6_din22", cap_din[22], 30);
`endif
        chk("s56_ndv", ndv, 8);
        idle(3, nact);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
